// File: rtl/tick_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tick_scheduler_pkg
// | Shared state encoding, physics widths and obstacle field-slice helpers.
// | Rev 1.0
// +----------------------------------------------------------------------------
package tick_scheduler_pkg;

    localparam int PHY_WIDTH        = 16;
    localparam int SIGNED_PHY_WIDTH = PHY_WIDTH + 1;
    localparam int N_OBS            = 7;
    localparam int BLOCK_PX         = 16;
    localparam int SCREEN_H         = 480;
    localparam int OBS_WBITS        = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SAMPLE = 3'd1,
        ST_SCAN   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_STEP   = 3'd4,
        ST_CAM    = 3'd5
    } sched_state_t;

    // LSB of field k inside a packed per-obstacle bus of field_w-bit entries.
    function automatic int obs_lsb(input int k, input int field_w);
        return k * field_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_scheduler_land.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | land_cmp
// | Registered single-obstacle landing comparator, one cycle of latency.
// | Rev 1.0
// +----------------------------------------------------------------------------
module land_cmp
    import tick_scheduler_pkg::*;
#(
    parameter int PHY_WIDTH = tick_scheduler_pkg::PHY_WIDTH,
    parameter int BLOCK_PX  = tick_scheduler_pkg::BLOCK_PX,
    parameter int CHAR_W    = 32,
    parameter int LAND_TOL  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PHY_WIDTH-1:0] char_x,
    input  logic [PHY_WIDTH:0]   char_y,
    input  logic [PHY_WIDTH-1:0] obs_x,
    input  logic [PHY_WIDTH-1:0] obs_y,
    input  logic [OBS_WBITS-1:0] obs_w,
    output logic                 hit
);

    localparam int SUM_W = PHY_WIDTH + 2;

    logic [SUM_W-1:0] w_x;
    logic [SUM_W-1:0] w_y;
    logic [SUM_W-1:0] w_ox;
    logic [SUM_W-1:0] w_oy;
    logic [SUM_W-1:0] w_x_right;
    logic [SUM_W-1:0] w_o_right;
    logic [SUM_W-1:0] w_o_top;
    logic             w_hit;
    logic             r_hit;

    // Two guard bits keep every sum exact; a negative y is rejected by its sign bit.
    always_comb begin
        w_x       = SUM_W'(char_x);
        w_y       = SUM_W'(char_y[PHY_WIDTH-1:0]);
        w_ox      = SUM_W'(obs_x);
        w_oy      = SUM_W'(obs_y);
        w_x_right = w_x + SUM_W'(CHAR_W);
        w_o_right = w_ox + SUM_W'(obs_w) * SUM_W'(BLOCK_PX);
        w_o_top   = w_oy + SUM_W'(LAND_TOL);
        w_hit     = (obs_w != '0) && !char_y[PHY_WIDTH]
                    && (w_x_right > w_ox) && (w_x < w_o_right)
                    && (w_y >= w_oy) && (w_y <= w_o_top);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit <= 1'b0;
        end else begin
            r_hit <= w_hit;
        end
    end

    assign hit = r_hit;

endmodule
`default_nettype wire

// File: rtl/tick_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tick_scheduler
// | Per-tick physics step sequencer: buttons, obstacle scan, step, camera.
// | Rev 1.0
// +----------------------------------------------------------------------------
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int PHY_WIDTH = tick_scheduler_pkg::PHY_WIDTH,
    parameter int N_OBS     = tick_scheduler_pkg::N_OBS,
    parameter int TICK_DIV  = 1024,
    parameter int BLOCK_PX  = tick_scheduler_pkg::BLOCK_PX,
    parameter int CHAR_W    = 32,
    parameter int LAND_TOL  = 8,
    parameter int SCREEN_H  = tick_scheduler_pkg::SCREEN_H,
    parameter int CAM_MAX   = 31
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         left_btn,
    input  logic                         right_btn,
    input  logic                         jump_btn,
    input  logic [PHY_WIDTH-1:0]         char_pos_x,
    input  logic [PHY_WIDTH:0]           char_pos_y,
    input  logic [N_OBS*PHY_WIDTH-1:0]   obstacle_abs_pos_x,
    input  logic [N_OBS*PHY_WIDTH-1:0]   obstacle_abs_pos_y,
    input  logic [N_OBS*OBS_WBITS-1:0]   obstacle_block_width,
    output logic                         step_en,
    output logic [2:0]                   btn_state,
    output logic [N_OBS-1:0]             hit_vec,
    output logic                         hit_any,
    output logic [2:0]                   hit_idx,
    output logic [4:0]                   camera_y,
    output logic                         regen_req,
    output logic                         busy,
    output logic                         overrun
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int IDX_W = (N_OBS > 1) ? $clog2(N_OBS) : 1;
    localparam int SUM_W = PHY_WIDTH + 2;

    sched_state_t          r_state;
    sched_state_t          w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_tick;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_issue;
    logic [IDX_W-1:0]      r_issue_idx;
    logic [PHY_WIDTH-1:0]  r_x;
    logic [PHY_WIDTH:0]    r_y;
    logic [2:0]            r_btn;
    logic                  r_jump_prev;
    logic                  r_jump_seen;
    logic [N_OBS-1:0]      r_hit_vec;
    logic [4:0]            r_cam;
    logic [PHY_WIDTH-1:0]  r_base;
    logic                  r_regen;
    logic                  r_overrun;
    logic                  w_rise;
    logic                  w_last;
    logic [PHY_WIDTH-1:0]  w_obs_x;
    logic [PHY_WIDTH-1:0]  w_obs_y;
    logic [OBS_WBITS-1:0]  w_obs_w;
    logic                  w_cmp_hit;
    logic [SUM_W-1:0]      w_y_mag;
    logic [SUM_W-1:0]      w_base;
    logic                  w_up;
    logic                  w_down;
    logic [2:0]            w_hit_idx;

    // Tick is registered so it is high exactly in the cycle the count reads 0.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == CNT_W'(TICK_DIV - 1));
            r_cnt  <= (r_cnt == CNT_W'(TICK_DIV - 1)) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_last = (r_idx == IDX_W'(N_OBS - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (r_tick) w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = ST_SCAN;
            ST_SCAN:   if (w_last) w_next = ST_DRAIN;
            ST_DRAIN:  w_next = ST_STEP;
            ST_STEP:   w_next = ST_CAM;
            ST_CAM:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign w_obs_x = obstacle_abs_pos_x[obs_lsb(int'(r_idx), PHY_WIDTH) +: PHY_WIDTH];
    assign w_obs_y = obstacle_abs_pos_y[obs_lsb(int'(r_idx), PHY_WIDTH) +: PHY_WIDTH];
    assign w_obs_w = obstacle_block_width[obs_lsb(int'(r_idx), OBS_WBITS) +: OBS_WBITS];

    land_cmp #(
        .PHY_WIDTH (PHY_WIDTH),
        .BLOCK_PX  (BLOCK_PX),
        .CHAR_W    (CHAR_W),
        .LAND_TOL  (LAND_TOL)
    ) u_land_cmp (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .char_x (r_x),
        .char_y (r_y),
        .obs_x  (w_obs_x),
        .obs_y  (w_obs_y),
        .obs_w  (w_obs_w),
        .hit    (w_cmp_hit)
    );

    assign w_rise = jump_btn & ~r_jump_prev;

    always_comb begin
        w_y_mag = SUM_W'(r_y[PHY_WIDTH-1:0]);
        w_base  = SUM_W'(r_base);
        w_up    = !r_y[PHY_WIDTH] && (w_y_mag >= w_base + SUM_W'(SCREEN_H))
                  && (r_cam < 5'(CAM_MAX));
        w_down  = (r_y[PHY_WIDTH] || (w_y_mag < w_base)) && (r_cam != '0);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_idx       <= '0;
            r_issue     <= 1'b0;
            r_issue_idx <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_btn       <= '0;
            r_jump_prev <= 1'b0;
            r_jump_seen <= 1'b0;
            r_hit_vec   <= '0;
            r_cam       <= '0;
            r_base      <= '0;
            r_regen     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_jump_prev <= jump_btn;
            r_regen     <= 1'b0;
            r_issue     <= (r_state == ST_SCAN);
            r_issue_idx <= r_idx;
            if (r_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            // A press landing in the SAMPLE cycle itself is carried to the next step.
            if (r_state == ST_SAMPLE) begin
                r_jump_seen <= w_rise;
            end else if (w_rise) begin
                r_jump_seen <= 1'b1;
            end
            if (r_state == ST_SAMPLE) begin
                r_x       <= char_pos_x;
                r_y       <= char_pos_y;
                r_btn     <= {r_jump_seen, right_btn, left_btn};
                r_hit_vec <= '0;
                r_idx     <= '0;
            end
            if ((r_state == ST_SCAN) && !w_last) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (r_issue) begin
                r_hit_vec[r_issue_idx] <= w_cmp_hit;
            end
            if (r_state == ST_CAM) begin
                if (w_up) begin
                    r_cam   <= r_cam + 5'd1;
                    r_base  <= r_base + PHY_WIDTH'(SCREEN_H);
                    r_regen <= 1'b1;
                end else if (w_down) begin
                    r_cam   <= r_cam - 5'd1;
                    r_base  <= r_base - PHY_WIDTH'(SCREEN_H);
                    r_regen <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_hit_idx = '0;
        for (int k = N_OBS - 1; k >= 0; k--) begin
            if (r_hit_vec[k]) w_hit_idx = 3'(k);
        end
    end

    assign step_en   = (r_state == ST_STEP);
    assign busy      = (r_state != ST_IDLE);
    assign btn_state = r_btn;
    assign hit_vec   = r_hit_vec;
    assign hit_any   = |r_hit_vec;
    assign hit_idx   = w_hit_idx;
    assign camera_y  = r_cam;
    assign regen_req = r_regen;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Sequences one physics step of the game per tick.
- Each step does four things in order:
  - latches the button state;
  - scans all platform obstacles through one shared landing comparator;
  - issues a single step strobe to the character physics block;
  - updates the vertical camera page and requests platform regeneration from the block generator.
- Sits between the character block, the block generator and the button inputs, and replaces the free-running divided character clock with a scheduled enable.

Parameters:
- PHY_WIDTH, 16, unsigned physics coordinate width; signed width is PHY_WIDTH+1.
- N_OBS, 7, number of obstacles scanned per step.
- TICK_DIV, 1024, sys_clk cycles per physics tick; must be ≥ N_OBS+6.
- BLOCK_PX, 16, pixel width of one obstacle width unit.
- CHAR_W, 32, character hitbox width in pixels.
- LAND_TOL, 8, vertical landing tolerance in pixels.
- SCREEN_H, 480, pixels per camera page.
- CAM_MAX, 31, highest camera page.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous, active-high reset.
- left_btn  in  1  level, already synchronised.
- right_btn  in  1  level, already synchronised.
- jump_btn  in  1  level, already synchronised.
- char_pos_x  in  PHY_WIDTH  character left edge, absolute.
- char_pos_y  in  PHY_WIDTH+1  character feet, absolute, signed.
- obstacle_abs_pos_x  in  N_OBS*PHY_WIDTH  packed; obstacle k at [k*PHY_WIDTH +: PHY_WIDTH].
- obstacle_abs_pos_y  in  N_OBS*PHY_WIDTH  packed, same layout.
- obstacle_block_width  in  N_OBS*4  packed; width in BLOCK_PX units.
- step_en  out  1  one-cycle pulse; character advances one physics step.
- btn_state  out  3  {jump_seen, right, left} latched at SAMPLE.
- hit_vec  out  N_OBS  landing result per obstacle; valid when step_en is high.
- hit_any  out  1  OR of hit_vec.
- hit_idx  out  3  lowest hit index; 0 if none.
- camera_y  out  5  current camera page.
- regen_req  out  1  one-cycle pulse when camera_y changes.
- busy  out  1  high whenever the FSM is not in IDLE.
- overrun  out  1  sticky; a tick arrived while busy.

Behaviour:
- Reset:
  - Applies on any sys_clk edge with sys_rst=1, including mid-step.
  - FSM returns to IDLE; divider counter clears to 0.
  - All outputs go to 0: camera_y=0, cam_base=0, overrun=0, jump_seen=0.
- Divider: counter runs 0..TICK_DIV-1; tick pulses for one cycle when the count wraps to 0.
- Jump capture: jump_seen is set on any jump_btn rising edge. It is cleared at SAMPLE unless a new rising edge occurs in that same cycle, so short presses between ticks are not lost.
- FSM states: IDLE, SAMPLE, SCAN, DRAIN, STEP, CAM.
- IDLE → SAMPLE on tick.
  - A tick in any other state is dropped and sets overrun.
- SAMPLE (1 cycle):
  - snapshot char_pos_x and char_pos_y;
  - latch btn_state;
  - clear hit_vec;
  - set idx=0.
- SCAN (N_OBS cycles):
  - mux obstacle idx into a single comparator; idx++ each cycle.
  - Comparator output is registered; result k is written to hit_vec[k] one cycle later.
  - After idx=N_OBS-1 is issued → DRAIN.
- DRAIN (1 cycle): write the last result → STEP.
- Landing rule for obstacle k, evaluated with snapshot values:
  - width_px = w*BLOCK_PX;
  - the rule holds when x+CHAR_W > ox, AND x < ox+width_px, AND y ≥ oy, AND y ≤ oy+LAND_TOL.
  - A negative y never hits.
  - w=0 never hits.
  - Sums are computed at PHY_WIDTH+2 bits; no wrap.
- STEP (1 cycle):
  - step_en=1;
  - hit_vec, hit_any and hit_idx are stable from this cycle until the next SAMPLE.
  - → CAM.
- CAM (1 cycle):
  - If y ≥ cam_base+SCREEN_H and camera_y < CAM_MAX: camera_y++, cam_base += SCREEN_H.
  - Else if y < cam_base and camera_y > 0: camera_y--, cam_base -= SCREEN_H.
  - Negative y counts as below.
  - At most one page per step.
  - regen_req=1 in the cycle after a change.
  - → IDLE.
- Latency: tick at cycle T gives step_en at T+N_OBS+3 and any regen_req at T+N_OBS+5.
- busy is high from SAMPLE through CAM.

Decomposition:
- Shared package holds:
  - the FSM state encoding;
  - PHY_WIDTH / SIGNED_PHY_WIDTH;
  - N_OBS, BLOCK_PX, SCREEN_H;
  - the obstacle field-slice helpers.
- One sub-module is natural: land_cmp, a registered single-obstacle landing comparator with one-cycle latency, reused by later collision work.

Test Plan:
- Reset then idle, TICK_DIV=32:
  - step_en pulses every 32 cycles;
  - each pulse is N_OBS+3 cycles after the tick;
  - busy is high for 11 cycles per step;
  - overrun stays 0.
- Character at x=286, y=682; obstacle 3 at ox=280, oy=680, w=4; all others at y=2000:
  - hit_vec=0001000, hit_any=1, hit_idx=3.
  - With y=689 instead: no hit.
- Obstacles 2 and 5 both satisfy the landing rule → hit_vec bits 2 and 5 set, hit_idx=2.
- Camera moves:
  - y=480 from camera_y=0 → camera_y=1, regen_req pulses once.
  - y=1500 held → camera 2 then 3 on successive steps.
  - y=−5 → camera_y decrements to 0 and holds.
- jump_btn high for 3 cycles mid-interval → btn_state[2]=1 at the next step and 0 at the following step.
- sys_rst asserted during SCAN:
  - next cycle busy=0, hit_vec=0, camera_y=0;
  - the first step_en after release arrives TICK_DIV+N_OBS+3 cycles later.
- Overrun check with TICK_DIV=N_OBS+6 and an external tick forced while busy → overrun=1 and stays set until reset.
